// File: rtl/lcd_pkg.sv
// Shared types, LCD command bytes and helpers for the LCD message sequencer.
package lcd_pkg;

    // Sequencer phases.
    typedef enum logic [2:0] {
        StIdle,
        StPwrup,
        StInit,
        StMsg,
        StDone
    } state_e;

    // Single-byte transfer engine phases.
    typedef enum logic [1:0] {
        XIdle,
        XSetup,
        XEnHi,
        XWait
    } xfer_e;

    // HD44780 command bytes.
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    // One shared width so every timing count fits, however the waits are tuned.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

    // Init command stream, in issue order.
    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = LCD_FUNC_SET;
            2'd1:    b = LCD_DISP_ON;
            2'd2:    b = LCD_CLEAR;
            default: b = LCD_ENTRY;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single-byte LCD write engine: SETUP, enable strobe, then a settle wait sized by the byte.
// ready is also raised in the last wait cycle so a back-to-back request costs no idle cycle.
module lcd_xfer
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYCLES = 16,
    parameter int unsigned CMD_WAIT  = 2500,
    parameter int unsigned CLR_WAIT  = 100000,
    parameter int unsigned PWR_WAIT  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_rs,
    input  logic [7:0] req_byte,
    output logic       ready,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam int unsigned CntW = cnt_width(PWR_WAIT, CLR_WAIT, CMD_WAIT, EN_CYCLES);
    localparam logic [CntW-1:0] EnLoad  = CntW'(EN_CYCLES - 1);
    localparam logic [CntW-1:0] CmdLoad = CntW'(CMD_WAIT - 1);
    localparam logic [CntW-1:0] ClrLoad = CntW'(CLR_WAIT - 1);

    xfer_e           xst_q, xst_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            last_wait;

    assign last_wait = (xst_q == XWait) && (cnt_q == '0);

    // Engine state, countdown and the latched rs/byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            xst_q  <= XIdle;
            cnt_q  <= '0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            xst_q  <= xst_d;
            cnt_q  <= cnt_d;
            rs_q   <= rs_d;
            data_q <= data_d;
        end
    end

    // Next-state: rs/byte are latched on accept and held until the next accept.
    always_comb begin
        xst_d  = xst_q;
        cnt_d  = cnt_q;
        rs_d   = rs_q;
        data_d = data_q;
        case (xst_q)
            XIdle: begin
                if (req) begin
                    xst_d  = XSetup;
                    rs_d   = req_rs;
                    data_d = req_byte;
                end
            end
            XSetup: begin
                xst_d = XEnHi;
                cnt_d = EnLoad;
            end
            XEnHi: begin
                if (cnt_q == '0) begin
                    xst_d = XWait;
                    // Clear needs the long settle time; everything else the short one.
                    cnt_d = (!rs_q && data_q == LCD_CLEAR) ? ClrLoad : CmdLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            XWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (req) begin
                    xst_d  = XSetup;
                    rs_d   = req_rs;
                    data_d = req_byte;
                end else begin
                    xst_d = XIdle;
                end
            end
            default: xst_d = XIdle;
        endcase
    end

    // Pin drive and handshake.
    always_comb begin
        ready    = (xst_q == XIdle) || last_wait;
        lcd_en   = (xst_q == XEnHi);
        lcd_rs   = rs_q;
        lcd_data = data_q;
    end

endmodule

// File: rtl/lcd_msg_sequencer.sv
// HD44780 16x2 sequencer: power-up wait, four init commands, then MSG_LEN ROM chars with a
// line-2 address command inserted before index LINE_LEN.
// Build option: define LCD_REFRESH_EN to home the cursor and rewrite the message forever,
// pulsing done at the end of each pass instead of stopping.
module lcd_msg_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned MSG_LEN   = 32,
    parameter int unsigned LINE_LEN  = 16,
    parameter int unsigned EN_CYCLES = 16,
    parameter int unsigned CMD_WAIT  = 2500,
    parameter int unsigned CLR_WAIT  = 100000,
    parameter int unsigned PWR_WAIT  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CntW = cnt_width(PWR_WAIT, CLR_WAIT, CMD_WAIT, EN_CYCLES);
    localparam logic [CntW-1:0] PwrLoad = CntW'(PWR_WAIT - 1);
    localparam logic [5:0]      LastIdx = 6'(MSG_LEN - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [1:0]      init_idx_q, init_idx_d;
    logic [5:0]      idx_q, idx_d;
    logic            line_done_q, line_done_d;
    logic            sent_last_q, sent_last_d;
    logic            done_q, done_d;

    logic            xfer_ready;
    logic            req;
    logic            req_rs;
    logic [7:0]      req_byte;
    logic            line_due;
    logic            unused_rom;

    assign unused_rom = ^rom_data[31:8];
    assign line_due   = (32'(idx_q) == LINE_LEN) && !line_done_q;

    lcd_xfer #(
        .EN_CYCLES (EN_CYCLES),
        .CMD_WAIT  (CMD_WAIT),
        .CLR_WAIT  (CLR_WAIT),
        .PWR_WAIT  (PWR_WAIT)
    ) u_xfer (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_rs   (req_rs),
        .req_byte (req_byte),
        .ready    (xfer_ready),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

    // Sequencer state register and pass bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pwr_cnt_q   <= '0;
            init_idx_q  <= 2'd0;
            idx_q       <= 6'd0;
            line_done_q <= 1'b0;
            sent_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            init_idx_q  <= init_idx_d;
            idx_q       <= idx_d;
            line_done_q <= line_done_d;
            sent_last_q <= sent_last_d;
            done_q      <= done_d;
        end
    end

    // Next-state: indices advance when the engine accepts a byte, so rom_addr already points
    // at the next char while the current one is still on the bus.
    always_comb begin
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        init_idx_d  = init_idx_q;
        idx_d       = idx_q;
        line_done_d = line_done_q;
        sent_last_d = sent_last_q;
        done_d      = done_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StPwrup;
                    pwr_cnt_d   = PwrLoad;
                    init_idx_d  = 2'd0;
                    idx_d       = 6'd0;
                    line_done_d = 1'b0;
                    sent_last_d = 1'b0;
                    done_d      = 1'b0;
                end
            end
            StPwrup: begin
                if (pwr_cnt_q == '0) begin
                    state_d = StInit;
                end else begin
                    pwr_cnt_d = pwr_cnt_q - CntW'(1);
                end
            end
            StInit: begin
                if (req) begin
                    if (init_idx_q == 2'd3) begin
                        state_d = StMsg;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end
            end
            StMsg: begin
`ifdef LCD_REFRESH_EN
                done_d = 1'b0;
`endif
                if (xfer_ready && sent_last_q) begin
                    // Last char has fully settled: the pass is over.
`ifdef LCD_REFRESH_EN
                    done_d      = 1'b1;
                    idx_d       = 6'd0;
                    line_done_d = 1'b0;
                    sent_last_d = 1'b0;
`else
                    state_d = StDone;
                    done_d  = 1'b1;
`endif
                end else if (req) begin
                    if (line_due) begin
                        line_done_d = 1'b1;
                    end else if (idx_q == LastIdx) begin
                        sent_last_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: engine request selection and status.
    always_comb begin
        req      = 1'b0;
        req_rs   = 1'b0;
        req_byte = 8'h00;
        case (state_q)
            StInit: begin
                if (xfer_ready) begin
                    req      = 1'b1;
                    req_byte = init_cmd(init_idx_q);
                end
            end
            StMsg: begin
                if (xfer_ready) begin
                    if (sent_last_q) begin
`ifdef LCD_REFRESH_EN
                        req      = 1'b1;
                        req_byte = LCD_LINE1;
`endif
                    end else if (line_due) begin
                        req      = 1'b1;
                        req_byte = LCD_LINE2;
                    end else begin
                        req      = 1'b1;
                        req_rs   = 1'b1;
                        req_byte = rom_data[7:0];
                    end
                end
            end
            default: ;
        endcase
        rom_addr = idx_q;
        lcd_rw   = 1'b0;
        lcd_on   = 1'b1;
        busy     = (state_q == StPwrup) || (state_q == StInit) || (state_q == StMsg);
        done     = done_q;
    end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Self-checking bench for lcd_msg_sequencer; define LCD_REFRESH_EN to exercise refresh mode.
module tb_lcd_msg_sequencer;

    localparam int unsigned MsgLen   = 32;
    localparam int unsigned LineLen  = 16;
    localparam int unsigned EnCycles = 2;
    localparam int unsigned CmdWait  = 4;
    localparam int unsigned ClrWait  = 8;
    localparam int unsigned PwrWait  = 10;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, done;

    logic [7:0]  rom_mem [64];
    string       msg = "HELLO FROM TEAM DE2-70 LCD READY";

    // Upper ROM bits carry junk that the DUT must ignore.
    assign rom_data = {8'hA5, 8'h5A, 2'b11, rom_addr, rom_mem[rom_addr]};

    always #5 clk = ~clk;

    lcd_msg_sequencer #(
        .MSG_LEN   (MsgLen),
        .LINE_LEN  (LineLen),
        .EN_CYCLES (EnCycles),
        .CMD_WAIT  (CmdWait),
        .CLR_WAIT  (ClrWait),
        .PWR_WAIT  (PwrWait)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_on   (lcd_on),
        .busy     (busy),
        .done     (done)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_pulses = 0;
    int         first_rise = 0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;
    int         gaps[$];
    logic [8:0] exp_q[$];
    logic [8:0] rise_val = 9'h000;
    logic       en_prev = 1'b0;
    logic       cut_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: scoreboard compare at each en rise, width/hold check at each fall.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (lcd_en && !en_prev) begin
                n_pulses++;
                if (n_pulses == 1) first_rise = cyc;
                gaps.push_back(cyc - fall_cyc);
                rise_cyc = cyc;
                rise_val = {lcd_rs, lcd_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: got rs=%0b data=%02h at pulse %0d, wanted none",
                             lcd_rs, lcd_data, n_pulses);
                end else begin
                    e = exp_q.pop_front();
                    if ({lcd_rs, lcd_data} !== e) begin
                        errors++;
                        $display("FAIL pulse_byte %0d: got rs=%0b data=%02h, wanted rs=%0b data=%02h",
                                 n_pulses, lcd_rs, lcd_data, e[8], e[7:0]);
                    end
                end
            end
            if (!lcd_en && en_prev) begin
                fall_cyc = cyc;
                if (cut_pulse) begin
                    cut_pulse = 1'b0;
                end else begin
                    checks++;
                    if (cyc - rise_cyc != int'(EnCycles)) begin
                        errors++;
                        $display("FAIL en_width pulse %0d: got %0d cycles, wanted %0d",
                                 n_pulses, cyc - rise_cyc, EnCycles);
                    end
                    checks++;
                    if ({lcd_rs, lcd_data} !== rise_val) begin
                        errors++;
                        $display("FAIL data_hold pulse %0d: got %03h at fall, wanted %03h",
                                 n_pulses, {lcd_rs, lcd_data}, rise_val);
                    end
                end
            end
            en_prev = lcd_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        exp_q.delete();
        gaps.delete();
        n_pulses   = 0;
        first_rise = 0;
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic push_pass();
        for (int i = 0; i < int'(MsgLen); i++) begin
            if (i == int'(LineLen)) exp_q.push_back({1'b0, 8'hC0});
            exp_q.push_back({1'b1, rom_mem[i]});
        end
    endtask

    // Pulse start for one cycle; returns the cycle number of the sampling edge.
    task automatic pulse_start(output int k0);
        start = 1'b1;
        tick();
        k0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int t = 0;
        while (done !== 1'b1 && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, wanted 1", tag, done, t);
        end
    endtask

    task automatic test_reset();
        logic seen = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({lcd_en, lcd_rs, lcd_rw, lcd_data} !== 11'h000) begin
            errors++;
            $display("FAIL reset_pins: got en/rs/rw/data=%03h, wanted 000",
                     {lcd_en, lcd_rs, lcd_rw, lcd_data});
        end
        checks++;
        if ({rom_addr, busy, done, lcd_on} !== 9'b000000_001) begin
            errors++;
            $display("FAIL reset_status: got addr/busy/done/on=%09b, wanted 000000001",
                     {rom_addr, busy, done, lcd_on});
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy || done || lcd_en) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || n_pulses != 0) begin
            errors++;
            $display("FAIL idle_quiet: got activity=%0b pulses=%0d, wanted 0 and 0", seen, n_pulses);
        end
        checks++;
        if (lcd_on !== 1'b1) begin
            errors++;
            $display("FAIL idle_lcd_on: got %0b, wanted 1", lcd_on);
        end
    endtask

`ifndef LCD_REFRESH_EN
    task automatic test_full_pass();
        int k0;
        clear_obs();
        push_init();
        push_pass();
        pulse_start(k0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_status: got busy=%0b done=%0b, wanted 1 0", busy, done);
        end
        wait_done(3000, "full_pass");
        checks++;
        if (first_rise - k0 < 11 || first_rise - k0 > 12) begin
            errors++;
            $display("FAIL first_en_delay: got %0d cycles, wanted 11..12", first_rise - k0);
        end
        // en-low gap between pulses is the settle wait plus the next SETUP cycle.
        checks++;
        if (gaps.size() < 5) begin
            errors++;
            $display("FAIL init_gaps: got %0d pulses, wanted at least 5", gaps.size());
        end else begin
            if (gaps[1] != int'(CmdWait) + 1 || gaps[2] != int'(CmdWait) + 1 ||
                gaps[3] != int'(ClrWait) + 1 || gaps[4] != int'(CmdWait) + 1) begin
                errors++;
                $display("FAIL init_gaps: got %0d %0d %0d %0d, wanted %0d %0d %0d %0d",
                         gaps[1], gaps[2], gaps[3], gaps[4], CmdWait + 1, CmdWait + 1,
                         ClrWait + 1, CmdWait + 1);
            end
        end
        checks++;
        if (n_pulses != 37 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL pass_count: got %0d pulses, %0d left, wanted 37 and 0",
                     n_pulses, exp_q.size());
        end
        checks++;
        if (busy !== 1'b0 || lcd_en !== 1'b0 || rom_addr !== 6'(MsgLen - 1)) begin
            errors++;
            $display("FAIL done_status: got busy=%0b en=%0b addr=%0d, wanted 0 0 %0d",
                     busy, lcd_en, rom_addr, MsgLen - 1);
        end
        repeat (20) tick();
        checks++;
        if (done !== 1'b1 || n_pulses != 37) begin
            errors++;
            $display("FAIL done_sticky: got done=%0b pulses=%0d, wanted 1 37", done, n_pulses);
        end
    endtask

    task automatic test_start_ignored();
        int k0;
        int t = 0;
        clear_obs();
        push_init();
        push_pass();
        pulse_start(k0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clears_done: got done=%0b busy=%0b, wanted 0 1", done, busy);
        end
        while (!(rom_addr == 6'd5 && busy) && t < 2000) begin
            tick();
            t++;
        end
        checks++;
        if (rom_addr !== 6'd5) begin
            errors++;
            $display("FAIL reach_idx5_timeout: got addr=%0d, wanted 5", rom_addr);
        end
        pulse_start(k0);
        checks++;
        if (busy !== 1'b1 || rom_addr < 6'd5) begin
            errors++;
            $display("FAIL busy_start_ignored: got busy=%0b addr=%0d, wanted 1 and >=5",
                     busy, rom_addr);
        end
        wait_done(3000, "ignored_start");
        repeat (20) tick();
        checks++;
        if (n_pulses != 37 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignored_start_count: got %0d pulses, %0d left, wanted 37 and 0",
                     n_pulses, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int k0;
        int t = 0;
        clear_obs();
        push_init();
        push_pass();
        pulse_start(k0);
        while (lcd_en !== 1'b1 && t < 500) begin
            tick();
            t++;
        end
        checks++;
        if (lcd_en !== 1'b1) begin
            errors++;
            $display("FAIL reach_en_timeout: got en=%0b, wanted 1", lcd_en);
        end
        cut_pulse = 1'b1;
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (lcd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset: got en=%0b busy=%0b done=%0b addr=%0d, wanted 0 0 0 0",
                     lcd_en, busy, done, rom_addr);
        end
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_beats_start: got busy=%0b, wanted 0", busy);
        end
        clear_obs();
        push_init();
        push_pass();
        pulse_start(k0);
        wait_done(3000, "replay");
        checks++;
        if (first_rise - k0 < 11 || first_rise - k0 > 12 || n_pulses != 37 ||
            exp_q.size() != 0) begin
            errors++;
            $display("FAIL replay: got delay=%0d pulses=%0d left=%0d, wanted 11..12 37 0",
                     first_rise - k0, n_pulses, exp_q.size());
        end
    endtask
`else
    task automatic test_refresh();
        int   k0;
        int   t = 0;
        int   n_done = 0;
        int   seen_at[2];
        logic busy_drop = 1'b0;
        seen_at[0] = -1;
        seen_at[1] = -1;
        clear_obs();
        push_init();
        push_pass();
        exp_q.push_back({1'b0, 8'h80});
        push_pass();
        pulse_start(k0);
        while (n_done < 2 && t < 4000) begin
            tick();
            t++;
            if (!busy) busy_drop = 1'b1;
            if (done) begin
                seen_at[n_done] = n_pulses;
                n_done++;
                if (n_done == 2) rst = 1'b1;
                tick();
                t++;
                rst = 1'b0;
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse_width: got done=%0b one cycle later, wanted 0", done);
                end
            end
        end
        checks++;
        if (n_done != 2) begin
            errors++;
            $display("FAIL refresh_timeout: got %0d done pulses, wanted 2", n_done);
        end
        checks++;
        if (seen_at[0] != 37 || seen_at[1] != 71) begin
            errors++;
            $display("FAIL refresh_pass_counts: got %0d %0d, wanted 37 71", seen_at[0], seen_at[1]);
        end
        checks++;
        if (busy_drop !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL refresh_busy: got busy_drop=%0b left=%0d, wanted 0 0",
                     busy_drop, exp_q.size());
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom_mem[i] = (i < int'(MsgLen)) ? msg.getc(i) : 8'h00;
        end
        test_reset();
`ifndef LCD_REFRESH_EN
        test_full_pass();
        test_start_ignored();
        test_reset_mid();
`else
        test_refresh();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
